psx_controller: RTL

Digital-pad responder for the PSX pad serial link. It plays the controller end opposite `psx_console`: it watches `att`, `psx_clk` and `cmd`, and answers the standard 5-byte poll LSB-first on `data`. It pulses `ack` after every byte except the last. It presents a 16-bit active-low button word, snapshotted at the start of each poll, and is used to emulate a pad on the T-Rex console bus or to close a bench loop around `psx_console`.

---
 rtl/psx_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/psx_controller.sv
// PSX digital-pad responder: answers the 5-byte console poll LSB-first on data
// and acknowledges each byte except the last with a timed low pulse on ack.
module psx_controller #(
    parameter int unsigned ACK_DELAY = 160,
    parameter int unsigned ACK_WIDTH = 32,
    parameter logic [7:0]  PAD_ID    = 8'h41
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        att,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic        poll_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT    = 3'd1;
    localparam logic [2:0] S_ACK_WAIT = 3'd2;
    localparam logic [2:0] S_ACK_LOW  = 3'd3;
    localparam logic [2:0] S_IGNORE   = 3'd4;

    localparam logic [15:0] DELAY_LAST = 16'(ACK_DELAY - 1);
    localparam logic [15:0] WIDTH_LAST = 16'(ACK_WIDTH - 1);

    // Index 0/1 form the synchronizer; index 2 is the history flop for edge detection.
    logic [2:0]  att_sync_q, pclk_sync_q;
    logic [1:0]  cmd_sync_q;
    logic [2:0]  state_q, state_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  rx_q, rx_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] ack_cnt_q, ack_cnt_d;
    logic        data_q, data_d;
    logic        ack_q, ack_d;
    logic        poll_done_q, poll_done_d;

    logic       att_high, att_fall, pclk_fall, pclk_rise, cmd_s;
    logic [7:0] rx_now;
    logic [7:0] next_reply;
    logic       check_fail;

    assign att_high  = att_sync_q[1];
    assign att_fall  = ~att_sync_q[1] & att_sync_q[2];
    assign pclk_fall = ~pclk_sync_q[1] & pclk_sync_q[2];
    assign pclk_rise = pclk_sync_q[1] & ~pclk_sync_q[2];
    assign cmd_s     = cmd_sync_q[1];

    assign data      = data_q;
    assign ack       = ack_q;
    assign poll_done = poll_done_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        bit_cnt_d   = bit_cnt_q;
        tx_byte_d   = tx_byte_q;
        rx_d        = rx_q;
        snap_d      = snap_q;
        ack_cnt_d   = ack_cnt_q;
        data_d      = data_q;
        ack_d       = ack_q;
        poll_done_d = 1'b0;

        rx_now            = rx_q;
        rx_now[bit_cnt_q] = cmd_s;

        case (byte_idx_q)
            3'd0:    next_reply = PAD_ID;
            3'd1:    next_reply = 8'h5A;
            3'd2:    next_reply = snap_q[7:0];
            3'd3:    next_reply = snap_q[15:8];
            default: next_reply = 8'hFF;
        endcase

        check_fail = ((byte_idx_q == 3'd0) && (rx_now != 8'h01)) ||
                     ((byte_idx_q == 3'd1) && (rx_now != 8'h42));

        if (state_q != S_IDLE && att_high) begin
            state_d = S_IDLE;
            data_d  = 1'b1;
            ack_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                    if (att_fall) begin
                        snap_d     = buttons;
                        byte_idx_d = 3'd0;
                        bit_cnt_d  = 3'd0;
                        tx_byte_d  = 8'hFF;
                        state_d    = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (pclk_fall) begin
                        data_d = tx_byte_q[bit_cnt_q];
                    end else if (pclk_rise) begin
                        rx_d      = rx_now;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d     = 1'b1;
                            tx_byte_d  = next_reply;
                            byte_idx_d = byte_idx_q + 3'd1;
                            ack_cnt_d  = 16'd0;
                            if (byte_idx_q == 3'd4) begin
                                poll_done_d = 1'b1;
                                state_d     = S_IGNORE;
                            end else if (check_fail) begin
                                state_d = S_IGNORE;
                            end else begin
                                state_d = S_ACK_WAIT;
                            end
                        end
                    end
                end
                S_ACK_WAIT: begin
                    // A console that clocks early cancels the ack and starts the next byte.
                    if (pclk_fall) begin
                        ack_d   = 1'b1;
                        data_d  = tx_byte_q[bit_cnt_q];
                        state_d = S_SHIFT;
                    end else if (ack_cnt_q == DELAY_LAST) begin
                        ack_d     = 1'b0;
                        ack_cnt_d = 16'd0;
                        state_d   = S_ACK_LOW;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 16'd1;
                    end
                end
                S_ACK_LOW: begin
                    if (pclk_fall) begin
                        ack_d   = 1'b1;
                        data_d  = tx_byte_q[bit_cnt_q];
                        state_d = S_SHIFT;
                    end else if (ack_cnt_q == WIDTH_LAST) begin
                        ack_d     = 1'b1;
                        ack_cnt_d = 16'd0;
                        state_d   = S_SHIFT;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 16'd1;
                    end
                end
                S_IGNORE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    data_d  = 1'b1;
                    ack_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            att_sync_q  <= 3'b111;
            pclk_sync_q <= 3'b111;
            cmd_sync_q  <= 2'b11;
            state_q     <= S_IDLE;
            byte_idx_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            tx_byte_q   <= 8'hFF;
            rx_q        <= 8'h00;
            snap_q      <= 16'hFFFF;
            ack_cnt_q   <= 16'd0;
            data_q      <= 1'b1;
            ack_q       <= 1'b1;
            poll_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            att_sync_q  <= {att_sync_q[1:0], att};
            pclk_sync_q <= {pclk_sync_q[1:0], psx_clk};
            cmd_sync_q  <= {cmd_sync_q[0], cmd};
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_byte_q   <= tx_byte_d;
            rx_q        <= rx_d;
            snap_q      <= snap_d;
            ack_cnt_q   <= ack_cnt_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            poll_done_q <= poll_done_d;
        end
    end

endmodule
